fpcacc: RTL and testbench
=========================

FPCACC -- requirements
Module: fpcacc

Interface
REQ-001 Parameter n, default 32: bit width of every real and imaginary data word.
REQ-002 Parameter d, default 16: number of fractional bits; the fixed-point format is Q(n-d).d, two's complement.
REQ-003 Parameter len, default 8: number of complex samples summed per output; legal range is 1 to 2^16.
REQ-004 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 snd_val  input  1  upstream complex product valid.
REQ-008 snd_rdy  output  1  block can accept a sample.
REQ-009 ar  input  n  real part of incoming sample (complex multiplier cr output).
REQ-010 ac  input  n  imaginary part of incoming sample (complex multiplier cc output).
REQ-011 rcv_val  output  1  accumulated sum valid.
REQ-012 rcv_rdy  input  1  downstream accepts sum.
REQ-013 cr  output  n  real part of accumulated sum.
REQ-014 cc  output  n  imaginary part of accumulated sum.

Function
REQ-015 An input transfer SHALL occur on a rising edge where snd_val and snd_rdy are both 1; an output transfer SHALL occur where rcv_val and rcv_rdy are both 1.
REQ-016 FSM states SHALL be ACC and DONE; snd_rdy SHALL be 1 exactly in ACC and rcv_val SHALL be 1 exactly in DONE.
REQ-017 In ACC, each input transfer SHALL add ar to the real accumulator and ac to the imaginary accumulator, and increment a sample counter.
REQ-018 On the input transfer that completes sample len, the FSM SHALL move to DONE, with cr/cc equal to the full len-sample sum on the next cycle (one-cycle latency from the last accept).
REQ-019 In DONE, cr, cc and rcv_val SHALL hold stable until an output transfer; snd_val SHALL be ignored.
REQ-020 On an output transfer the FSM SHALL return to ACC with both accumulators and the counter cleared to 0; the next input SHALL not be accepted before the following cycle.
REQ-021 Addition SHALL be n-bit two's complement with wrap-around on overflow; no saturation and no rescaling, because addition preserves the d-bit binary point.
REQ-022 Cycles in ACC with snd_val=0 SHALL leave all state unchanged; gaps between samples are unlimited.
REQ-023 For len=1, every input transfer SHALL go directly to DONE with cr=ar and cc=ac.
REQ-024 While in ACC, cr/cc SHALL show the running partial sum; consumers SHALL only use them when rcv_val=1.

Reset
REQ-025 When reset=1 at a rising edge, the FSM SHALL enter ACC, with the counter, both accumulators, cr and cc set to 0, rcv_val=0 and snd_rdy=1.
REQ-026 Reset SHALL take priority over any simultaneous transfer, including a reset in the middle of a sum or while in DONE; the partial sum SHALL be discarded.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (ACC, DONE) and the counter-width constant ($clog2(len+1)); it is shared with future FFT-stage blocks.
REQ-028 No sub-module SHALL be used; the FSM, counter and two accumulator registers SHALL be implemented inside fpcacc.

Verification
REQ-029 Use n=32, d=16, len=4 unless stated. Each scenario is stimulus -> required response.
- Reset check: assert reset, then release -> snd_rdy=1, rcv_val=0, cr=cc=0.
- Basic sum: four back-to-back samples (0x00010000, 0x00008000) -> one cycle after the 4th accept, rcv_val=1, cr=0x00040000, cc=0x00020000.
- Signed sum: samples ar = {+1.0, -2.0, +0.5, -0.25}, ac = 0 -> cr=0xFFFF4000 (-0.75), cc=0.
- Gaps and backpressure: random snd_val gaps and rcv_rdy held 0 for 5 cycles -> sum unchanged, snd_rdy=0 throughout DONE, result accepted on the first cycle rcv_rdy=1, and the next sum starts from 0.
- Wrap: four samples ar=0x40000000 -> cr=0x00000000 (wrap), with no error indication.
- Reset mid-sum: reset after 2 samples, then 4 samples of 0x00010000 -> cr=0x00040000 (pre-reset samples excluded); a separate len=1 build passes each sample straight through.

Source files
------------

// File: rtl/fpcacc_pkg.sv
// Shared definitions for the complex accumulator and the FFT-stage blocks built around it.
`timescale 1ns/1ps
package fpcacc_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam int LEN_DEFAULT   = 8;
    localparam int CNT_W_DEFAULT = $clog2(LEN_DEFAULT + 1);

    // Counter width that can hold the values 0..len.
    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/fpcacc.sv
// Fixed-point complex accumulator: sums len complex samples, then holds the result
// until the consumer takes it.
`timescale 1ns/1ps
module fpcacc
    import fpcacc_pkg::*;
#(
    parameter int n   = 32,
    parameter int d   = 16,
    parameter int len = LEN_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         snd_val,
    output logic         snd_rdy,
    input  logic [n-1:0] ar,
    input  logic [n-1:0] ac,
    output logic         rcv_val,
    input  logic         rcv_rdy,
    output logic [n-1:0] cr,
    output logic [n-1:0] cc
);

    localparam int            CW   = cnt_width(len);
    localparam logic [CW-1:0] LAST = CW'(len - 1);

    // The binary point never moves under addition, so d only constrains legal builds.
    if (d < 0 || d > n) begin : g_bad_frac
        $error("fpcacc: fractional bits d must lie in 0..n");
    end
    if (len < 1 || len > 65536) begin : g_bad_len
        $error("fpcacc: len must lie in 1..65536");
    end

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [n-1:0]  r_acc_r;
    logic [n-1:0]  r_acc_c;
    logic          w_in_xfer;
    logic          w_out_xfer;
    logic          w_last;

    assign snd_rdy    = (r_state == ACC);
    assign rcv_val    = (r_state == DONE);
    assign w_in_xfer  = snd_val & snd_rdy;
    assign w_out_xfer = rcv_val & rcv_rdy;
    assign w_last     = (r_cnt == LAST);
    assign cr         = r_acc_r;
    assign cc         = r_acc_c;

    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACC:     if (w_in_xfer && w_last) w_state_nxt = DONE;
            DONE:    if (w_out_xfer)          w_state_nxt = ACC;
            default: w_state_nxt = ACC;
        endcase
    end

    // Accumulators wrap modulo 2^n; the result stays in them while DONE holds.
    always_ff @(posedge clk) begin
        if (reset || w_out_xfer) begin
            r_cnt   <= '0;
            r_acc_r <= '0;
            r_acc_c <= '0;
        end else if (w_in_xfer) begin
            r_cnt   <= r_cnt + 1'b1;
            r_acc_r <= r_acc_r + ar;
            r_acc_c <= r_acc_c + ac;
        end
    end

endmodule

// File: tb/tb_fpcacc.sv
// Self-checking bench for fpcacc: len=4 build against a sum model, plus a len=1 build.
`timescale 1ns/1ps
module tb_fpcacc;

    localparam int LEN = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        snd_val, snd_rdy, rcv_val, rcv_rdy;
    logic [31:0] ar, ac, cr, cc;
    logic        s_val1, s_rdy1, r_val1, r_rdy1;
    logic [31:0] ar1, ac1, cr1, cc1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fpcacc #(.n(32), .d(16), .len(LEN)) dut (
        .clk(clk), .reset(reset), .snd_val(snd_val), .snd_rdy(snd_rdy),
        .ar(ar), .ac(ac), .rcv_val(rcv_val), .rcv_rdy(rcv_rdy), .cr(cr), .cc(cc)
    );

    fpcacc #(.n(32), .d(16), .len(1)) dut1 (
        .clk(clk), .reset(reset), .snd_val(s_val1), .snd_rdy(s_rdy1),
        .ar(ar1), .ac(ac1), .rcv_val(r_val1), .rcv_rdy(r_rdy1), .cr(cr1), .cc(cc1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: the sum of the samples accepted since the last clear, and whether len of them are in.
    logic [31:0] m_sum_r = '0, m_sum_c = '0;
    int          m_n     = 0;
    bit          m_done  = 1'b0;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_sum_r = '0; m_sum_c = '0; m_n = 0; m_done = 1'b0; m_valid = 1'b1;
        end else if (m_done) begin
            if (rcv_rdy) begin
                m_sum_r = '0; m_sum_c = '0; m_n = 0; m_done = 1'b0;
            end
        end else if (snd_val) begin
            m_sum_r = m_sum_r + ar;
            m_sum_c = m_sum_c + ac;
            m_n     = m_n + 1;
            m_done  = (m_n == LEN);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_snd_rdy", {31'b0, snd_rdy}, {31'b0, ~m_done});
            check("model_rcv_val", {31'b0, rcv_val}, {31'b0, m_done});
            check("model_cr", cr, m_sum_r);
            check("model_cc", cc, m_sum_c);
        end
    end

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] r, input logic [31:0] c);
        snd_val = 1'b1; ar = r; ac = c;
        for (int k = 0; k < 50 && !snd_rdy; k++) idle(1);
        if (!snd_rdy) check("send_timeout", {31'b0, snd_rdy}, 32'd1);
        else          idle(1);
        snd_val = 1'b0;
    endtask

    task automatic recv(input string name, input logic [31:0] er, input logic [31:0] ec);
        for (int k = 0; k < 50 && !rcv_val; k++) idle(1);
        check({name, "_rcv_val"}, {31'b0, rcv_val}, 32'd1);
        check({name, "_cr"}, cr, er);
        check({name, "_cc"}, cc, ec);
        rcv_rdy = 1'b1;
        idle(1);
        rcv_rdy = 1'b0;
        check({name, "_back_to_acc"}, {31'b0, snd_rdy}, 32'd1);
        check({name, "_cleared"}, cr, 32'h0);
    endtask

    logic [31:0] t1_r [3] = '{32'h00010000, 32'hFFFE0000, 32'h7FFFFFFF};
    logic [31:0] t1_c [3] = '{32'h00008000, 32'h00000000, 32'h80000000};

    initial begin
        reset = 1'b1; snd_val = 1'b0; rcv_rdy = 1'b0; ar = '0; ac = '0;
        s_val1 = 1'b0; r_rdy1 = 1'b0; ar1 = '0; ac1 = '0;
        idle(2);
        reset = 1'b0;
        check("rst_snd_rdy", {31'b0, snd_rdy}, 32'd1);
        check("rst_rcv_val", {31'b0, rcv_val}, 32'd0);
        check("rst_cr", cr, 32'h0);
        check("rst_cc", cc, 32'h0);

        // Basic back-to-back sum; result visible the cycle after the 4th accept.
        repeat (4) send(32'h00010000, 32'h00008000);
        check("basic_latency", {31'b0, rcv_val}, 32'd1);
        recv("basic", 32'h00040000, 32'h00020000);

        // Signed: +1.0 - 2.0 + 0.5 - 0.25 = -0.75
        send(32'h00010000, 32'h0);
        send(32'hFFFE0000, 32'h0);
        send(32'h00008000, 32'h0);
        send(32'hFFFFC000, 32'h0);
        recv("signed", 32'hFFFF4000, 32'h0);

        // Gaps, then 5 cycles of backpressure with snd_val asserted and ignored.
        repeat (4) begin
            idle($urandom_range(0, 3));
            send(32'h00011000, 32'hFFFFF000);
        end
        snd_val = 1'b1; ar = 32'h7FFFFFFF; ac = 32'h7FFFFFFF;
        repeat (5) begin
            idle(1);
            check("hold_snd_rdy", {31'b0, snd_rdy}, 32'd0);
            check("hold_cr", cr, 32'h00044000);
        end
        snd_val = 1'b0;
        recv("gaps", 32'h00044000, 32'hFFFFC000);
        repeat (4) send(32'h00010000, 32'h0);
        recv("after_gaps", 32'h00040000, 32'h0);

        // Wrap-around on overflow in both directions.
        repeat (4) send(32'h40000000, 32'h20000000);
        recv("wrap", 32'h00000000, 32'h80000000);

        // Reset in the middle of a sum discards the partial result.
        repeat (2) send(32'h00050000, 32'h00050000);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("midrst_cr", cr, 32'h0);
        check("midrst_snd_rdy", {31'b0, snd_rdy}, 32'd1);
        repeat (4) send(32'h00010000, 32'h0);
        recv("midrst", 32'h00040000, 32'h0);

        // len=1 build: each accepted sample is the result.
        for (int i = 0; i < 3; i++) begin
            s_val1 = 1'b1; ar1 = t1_r[i]; ac1 = t1_c[i];
            check("len1_ready", {31'b0, s_rdy1}, 32'd1);
            idle(1);
            s_val1 = 1'b0;
            check("len1_rcv_val", {31'b0, r_val1}, 32'd1);
            check("len1_cr", cr1, t1_r[i]);
            check("len1_cc", cc1, t1_c[i]);
            r_rdy1 = 1'b1;
            idle(1);
            r_rdy1 = 1'b0;
            check("len1_cleared", cr1, 32'h0);
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
